// File: rtl/clock_set_ctrl.sv
// Live h:m:s time keeper plus the RUN/SET mode machine used to edit and commit a new time.
// Optional macro SET_TIMEOUT_EN: idle time in a SET mode auto-cancels back to RUN.
module clock_set_ctrl #(
  parameter int TIMEOUT_MS = 10000,
  parameter int BLINK_MS   = 500
) (
  input  logic       Millisecond_in,
  input  logic       Reset,
  input  logic [0:3] KEY_in,
  input  logic       Second_tick,
  output logic [4:0] Hour_out,
  output logic [5:0] Minute_out,
  output logic [5:0] Second_out,
  output logic [1:0] Mode_out,
  output logic       Blink_out
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_SET_HOUR = 2'd1,
    ST_SET_MIN  = 2'd2,
    ST_SET_SEC  = 2'd3
  } state_t;

  localparam int BW = $clog2(BLINK_MS + 1);

  state_t        state_reg, state_next;
  logic [0:3]    key_reg, press_reg, press_next;
  logic [4:0]    live_h_reg, live_h_next, edit_h_reg, edit_h_next;
  logic [5:0]    live_m_reg, live_m_next, edit_m_reg, edit_m_next;
  logic [5:0]    live_s_reg, live_s_next, edit_s_reg, edit_s_next;
  logic [4:0]    disp_h_reg;
  logic [5:0]    disp_m_reg, disp_s_reg;
  logic          blink_reg, blink_next, blink_restart;
  logic [BW-1:0] blink_cnt_reg, blink_cnt_next;
  logic          in_set, any_press, timeout_hit;
  logic          do_cancel, do_mode, do_inc, do_dec, commit;
  logic [5:0]    hour_step;

  function automatic logic [5:0] step_field(input logic [5:0] v, input logic [5:0] max_v,
                                            input logic up);
    logic [5:0] r;
    if (up) r = (v == max_v) ? 6'd0 : v + 6'd1;
    else    r = (v == 6'd0) ? max_v : v - 6'd1;
    return r;
  endfunction

  // A press is a high-to-low step between the previous registered sample and the new one.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_press
      assign press_next[gi] = key_reg[gi] & ~KEY_in[gi];
    end
  endgenerate

  assign in_set    = (state_reg != ST_RUN);
  assign any_press = |press_reg;

`ifdef SET_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_MS + 1);
  logic [TW-1:0] idle_cnt_reg, idle_cnt_next;

  always_comb begin
    idle_cnt_next = '0;
    if (!any_press && in_set) idle_cnt_next = idle_cnt_reg + 1'b1;
  end

  assign timeout_hit = in_set && !any_press && (idle_cnt_reg == TW'(TIMEOUT_MS - 1));

  always_ff @(posedge Millisecond_in or posedge Reset) begin
    if (Reset) idle_cnt_reg <= '0;
    else       idle_cnt_reg <= idle_cnt_next;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Fixed priority CANCEL > MODE > INC > DEC; a losing press is simply dropped.
  assign do_cancel = in_set && (press_reg[3] || timeout_hit);
  assign do_mode   = press_reg[0] && !press_reg[3];
  assign do_inc    = in_set && press_reg[1] && !press_reg[3] && !press_reg[0];
  assign do_dec    = in_set && press_reg[2] && !press_reg[3] && !press_reg[0] && !press_reg[1];
  assign commit    = do_mode && (state_reg == ST_SET_SEC);

  always_comb begin
    state_next    = state_reg;
    live_h_next   = live_h_reg;
    live_m_next   = live_m_reg;
    live_s_next   = live_s_reg;
    edit_h_next   = edit_h_reg;
    edit_m_next   = edit_m_reg;
    edit_s_next   = edit_s_reg;
    blink_restart = 1'b0;
    hour_step     = '0;

    // A commit overrides a coincident tick; that tick is intentionally lost.
    if (commit) begin
      live_h_next = edit_h_reg;
      live_m_next = edit_m_reg;
      live_s_next = edit_s_reg;
    end else if (Second_tick) begin
      if (live_s_reg == 6'd59) begin
        live_s_next = '0;
        if (live_m_reg == 6'd59) begin
          live_m_next = '0;
          live_h_next = (live_h_reg == 5'd23) ? 5'd0 : live_h_reg + 5'd1;
        end else begin
          live_m_next = live_m_reg + 6'd1;
        end
      end else begin
        live_s_next = live_s_reg + 6'd1;
      end
    end

    if (do_cancel) begin
      state_next = ST_RUN;
    end else if (do_mode) begin
      case (state_reg)
        ST_RUN: begin
          state_next    = ST_SET_HOUR;
          edit_h_next   = live_h_next;
          edit_m_next   = live_m_next;
          edit_s_next   = live_s_next;
          blink_restart = 1'b1;
        end
        ST_SET_HOUR: state_next = ST_SET_MIN;
        ST_SET_MIN:  state_next = ST_SET_SEC;
        default:     state_next = ST_RUN;
      endcase
    end else if (do_inc || do_dec) begin
      blink_restart = 1'b1;
      case (state_reg)
        ST_SET_HOUR: begin
          hour_step   = step_field({1'b0, edit_h_reg}, 6'd23, do_inc);
          edit_h_next = hour_step[4:0];
        end
        ST_SET_MIN: edit_m_next = step_field(edit_m_reg, 6'd59, do_inc);
        default:    edit_s_next = step_field(edit_s_reg, 6'd59, do_inc);
      endcase
    end
  end

  always_comb begin
    blink_next     = blink_reg;
    blink_cnt_next = blink_cnt_reg;
    if (state_next == ST_RUN || blink_restart) begin
      blink_next     = 1'b1;
      blink_cnt_next = '0;
    end else if (blink_cnt_reg == BW'(BLINK_MS - 1)) begin
      blink_next     = ~blink_reg;
      blink_cnt_next = '0;
    end else begin
      blink_cnt_next = blink_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge Millisecond_in or posedge Reset) begin
    if (Reset) begin
      state_reg     <= ST_RUN;
      key_reg       <= 4'b1111;
      press_reg     <= '0;
      live_h_reg    <= '0;
      live_m_reg    <= '0;
      live_s_reg    <= '0;
      edit_h_reg    <= '0;
      edit_m_reg    <= '0;
      edit_s_reg    <= '0;
      disp_h_reg    <= '0;
      disp_m_reg    <= '0;
      disp_s_reg    <= '0;
      blink_reg     <= 1'b1;
      blink_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      key_reg       <= KEY_in;
      press_reg     <= press_next;
      live_h_reg    <= live_h_next;
      live_m_reg    <= live_m_next;
      live_s_reg    <= live_s_next;
      edit_h_reg    <= edit_h_next;
      edit_m_reg    <= edit_m_next;
      edit_s_reg    <= edit_s_next;
      disp_h_reg    <= (state_next == ST_RUN) ? live_h_next : edit_h_next;
      disp_m_reg    <= (state_next == ST_RUN) ? live_m_next : edit_m_next;
      disp_s_reg    <= (state_next == ST_RUN) ? live_s_next : edit_s_next;
      blink_reg     <= blink_next;
      blink_cnt_reg <= blink_cnt_next;
    end
  end

  assign Hour_out   = disp_h_reg;
  assign Minute_out = disp_m_reg;
  assign Second_out = disp_s_reg;
  assign Mode_out   = state_reg;
  assign Blink_out  = blink_reg;

endmodule

// File: doc/clock_set_ctrl.md
# clock_set_ctrl

Time-keeping and time-setting controller for the clock design. Sits directly downstream of the key debouncer: it consumes the four debounced, active-low key pulses and a one-cycle 1 Hz strobe, keeps the live hour/minute/second count, and runs the mode state machine that lets the user edit and commit a new time. Outputs feed the display multiplexer.

## Interface
- TIMEOUT_MS, 10000: idle time in SET modes before automatic cancel (only with SET_TIMEOUT_EN).
- BLINK_MS, 500: half-period of the edit-field blink.
- Millisecond_in  input  1  1 kHz system clock, rising edge.
- Reset  input  1  asynchronous, active-high reset.
- KEY_in  input  [0:3]  debounced keys, active-low; bit0 MODE, bit1 INC, bit2 DEC, bit3 CANCEL.
- Second_tick  input  1  one-cycle-high strobe, once per second.
- Hour_out  output  5  displayed hour, 0–23.
- Minute_out  output  6  displayed minute, 0–59.
- Second_out  output  6  displayed second, 0–59.
- Mode_out  output  2  0 RUN, 1 SET_HOUR, 2 SET_MIN, 3 SET_SEC.
- Blink_out  output  1  1 = edited field visible, 0 = blanked.

## Operation
- One clock, Millisecond_in. Reset is asynchronous and active-high. Reset clears all outputs: Hour/Minute/Second = 0, Mode_out = 0 (RUN), Blink_out = 1. Live and edit registers, counters, and key history are also cleared. Key history resets to 4'b1111.
- Key press detection:
  - KEY_in is registered.
  - A press is a 1→0 transition of the registered value. A key held low acts once.
  - Simultaneous presses have fixed priority: CANCEL > MODE > INC > DEC. Lower-priority presses in the same cycle are dropped.
- Live time:
  - Increments on every Second_tick in all modes; the clock never pauses.
  - Seconds carry from 59 to 0 into minutes; minutes carry from 59 to 0 into hours.
  - 23:59:59 + tick gives 00:00:00.
- Mode state machine:
  - RUN –MODE→ SET_HOUR: edit registers are loaded from live time.
  - SET_HOUR –MODE→ SET_MIN –MODE→ SET_SEC.
  - SET_SEC –MODE→ RUN: commit, i.e. edit registers are copied into live time.
  - CANCEL in any SET state → RUN with no commit.
  - CANCEL in RUN is ignored.
- Editing:
  - INC/DEC change only the field selected by the mode, and change the edit registers only.
  - Hour wraps 23→0 and 0→23. Minute and second wrap 59→0 and 0→59.
  - No carry between fields while editing.
  - INC/DEC in RUN are ignored.
- Display: outputs show the live registers in RUN and the edit registers in SET states.
- Blink:
  - In SET states, Blink_out toggles every BLINK_MS cycles.
  - Blink_out is forced to 1 and the blink counter restarts on SET_HOUR entry and on every INC/DEC.
  - In RUN, Blink_out = 1.
- Commit coinciding with a Second_tick: the committed value is loaded and that tick is discarded.
- Second_tick arriving during a SET state advances live time only; it has no effect on the edit registers.
- Reset asserted mid-edit: returns to RUN with 00:00:00. Edits are lost.

## Timing
- A key sampled low at rising edge n (previous sample high) is detected after edge n. The state or field change is visible after edge n+1. Latency is 2 clocks from KEY_in falling.
- Second_tick high at edge n: live time is updated after edge n. Latency is 1 clock.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Blink: first toggle occurs BLINK_MS cycles after SET entry or after the last INC/DEC.

## Configuration
- SET_TIMEOUT_EN:
  - Defined: a counter clears on every detected press and counts cycles while in a SET state.
  - When the count reaches TIMEOUT_MS, the block behaves exactly as CANCEL: → RUN, no commit.
  - A press in the same cycle as the timeout wins; the counter clears.
  - Not defined: the counter is absent and SET states persist indefinitely.

## Test plan
- Reset, then 3661 Second_tick pulses → Hour_out = 1, Minute_out = 1, Second_out = 1, Mode_out = 0, Blink_out = 1.
- Live time 23:59:59 + one tick → 00:00:00.
- RUN at 10:20:30. Sequence: MODE, DEC ×11, MODE, INC ×45, MODE, INC ×30, MODE → Mode_out = 0 and time = 23:05:00, assuming no ticks during the sequence.
- In SET_MIN, CANCEL and INC pulsed in the same cycle → Mode_out = 0. Display shows untouched live time. Minute is not incremented.
- KEY_in bit1 held low for 50 cycles in SET_HOUR at hour 5 → hour = 6 exactly once. Blink_out stays 1 for 500 cycles, then toggles.
- With SET_TIMEOUT_EN defined: enter SET_HOUR, INC once, then idle 10000 cycles → Mode_out returns to 0 and live hour is unchanged. Without the macro: Mode_out remains 1.
